// File: rtl/share_checker.sv
// Qualifies double-SHA finisher results against a 64-bit target, queues qualifying
// nonces in a show-ahead FIFO for the host-link sender, and keeps hash/share/drop stats.
module share_checker #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          accepted,
   input  logic [255:0]  hash,
   input  logic [31:0]   nonce,
   input  logic [63:0]   target,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_nonce,
   output logic [63:0]   out_hash_hi,
   output logic [AW:0]   fifo_level,
   output logic [31:0]   hash_count,
   output logic [15:0]   share_count,
   output logic [15:0]   drop_count
);

   localparam int unsigned NW = 32;
   localparam int unsigned TW = 64;
   localparam int unsigned LW = AW + 1;

   typedef struct packed {
      logic [NW-1:0] nonce;
      logic [TW-1:0] top;
   } entry_t;

   logic [1:0]    rst_sync;
   logic          rst_n_s;
   logic          acc_d;
   logic          cap_v;
   logic [NW-1:0] cap_nonce;
   logic [TW-1:0] cap_top;
   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic          qualify_c;
   logic          pop_c;
   logic          full_c;
   logic          push_c;
   logic          drop_c;
   logic [LW-1:0] level_pop_c;
   logic [LW-1:0] level_nxt_c;
   logic [AW-1:0] rd_nxt_c;
   entry_t        head_nxt_c;
   logic          unused_hash_lo;

   assign unused_hash_lo = ^hash[191:0];

   // Reset asserts immediately, releases two edges after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_s = rst_sync[1];

   // S0 strobe delay and S1 capture of the finisher result.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         acc_d     <= 1'b0;
         cap_v     <= 1'b0;
         cap_nonce <= '0;
         cap_top   <= '0;
      end else begin
         acc_d <= accepted & enable;
         cap_v <= acc_d;
         if (acc_d) begin
            cap_nonce <= nonce;
            cap_top   <= hash[255:192];
         end
      end
   end

   // S2 qualify plus FIFO bookkeeping; head is pre-computed so outputs stay registered.
   always_comb begin
      qualify_c   = cap_v & (cap_top <= target);
      pop_c       = out_valid & out_ready;
      full_c      = (fifo_level == LW'(DEPTH));
      push_c      = qualify_c & (~full_c | pop_c);
      drop_c      = qualify_c & full_c & ~pop_c;
      level_pop_c = fifo_level - LW'(pop_c);
      level_nxt_c = level_pop_c + LW'(push_c);
      rd_nxt_c    = pop_c ? rd_ptr + AW'(1) : rd_ptr;
      head_nxt_c  = {out_nonce, out_hash_hi};
      if (level_pop_c != '0)
         head_nxt_c = mem[rd_nxt_c];
      else if (push_c)
         head_nxt_c = {cap_nonce, cap_top};
   end

   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_level  <= '0;
         out_valid   <= 1'b0;
         out_nonce   <= '0;
         out_hash_hi <= '0;
         hash_count  <= '0;
         share_count <= '0;
         drop_count  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr      <= rd_nxt_c;
         fifo_level  <= level_nxt_c;
         out_valid   <= (level_nxt_c != '0);
         out_nonce   <= head_nxt_c.nonce;
         out_hash_hi <= head_nxt_c.top;
         hash_count  <= hash_count + 32'(acc_d);
         share_count <= share_count + 16'(qualify_c);
         if (drop_c && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= {cap_nonce, cap_top};
   end

endmodule

// File: tb/tb_share_checker.sv
// Scoreboard bench for share_checker: driver records issued results, a negedge monitor
// advances a queue-based reference model and compares every DUT output.
module tb_share_checker;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable = 1'b0;
   logic          accepted = 1'b0;
   logic [255:0]  hash = '0;
   logic [31:0]   nonce = '0;
   logic [63:0]   target = '0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [31:0]   out_nonce;
   logic [63:0]   out_hash_hi;
   logic [AW:0]   fifo_level;
   logic [31:0]   hash_count;
   logic [15:0]   share_count;
   logic [15:0]   drop_count;

   share_checker #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .accepted(accepted),
      .hash(hash), .nonce(nonce), .target(target),
      .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce),
      .out_hash_hi(out_hash_hi), .fifo_level(fifo_level), .hash_count(hash_count),
      .share_count(share_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int pos_cnt = 0;
   always @(posedge clk) pos_cnt++;

   typedef struct {
      int          hedge;
      int          pedge;
      logic [31:0] n;
      logic [63:0] top;
   } ev_t;
   typedef struct {
      logic [31:0] n;
      logic [63:0] top;
   } ent_t;

   ev_t         pend[$];
   ent_t        mq[$];
   logic [31:0] m_hash = '0;
   logic [15:0] m_share = '0;
   int          m_drop = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   bit          mon_on = 1'b0;
   int          ready_mode = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: compare against the model, then advance the model across the next edge.
   initial forever begin
      @(negedge clk);
      #2;
      if (!mon_on) begin
         out_ready = 1'b0;
         continue;
      end
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("hash_count", 64'(hash_count), 64'(m_hash));
      chk("share_count", 64'(share_count), 64'(m_share));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      if (mq.size() != 0) begin
         chk("out_nonce", 64'(out_nonce), 64'(mq[0].n));
         chk("out_hash_hi", out_hash_hi, mq[0].top);
      end
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      foreach (pend[i]) begin
         if (pend[i].hedge == pos_cnt + 1) m_hash++;
         if (pend[i].pedge == pos_cnt + 1 && pend[i].top <= target) begin
            m_share++;
            if (mq.size() < DEPTH) mq.push_back('{n: pend[i].n, top: pend[i].top});
            else if (m_drop < 65535) m_drop++;
         end
      end
      while (pend.size() != 0 && pend[0].pedge <= pos_cnt + 1) void'(pend.pop_front());
   end

   task automatic strobe(input logic [31:0] nn, input logic [63:0] top);
      @(negedge clk);
      accepted = 1'b1;
      if (enable) pend.push_back('{hedge: pos_cnt + 2, pedge: pos_cnt + 3, n: nn, top: top});
      @(negedge clk);
      accepted = 1'b0;
      hash = {top, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      nonce = nn;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      ready_mode = 1;
      for (int i = 0; i < 200 && (mq.size() != 0 || pend.size() != 0); i++) @(negedge clk);
      idle(2);
      chk("drain_done", 64'(mq.size() + pend.size()), 64'd0);
   endtask

   task automatic reset_pulse(input int hold);
      mon_on = 1'b0;
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_fifo_level", 64'(fifo_level), 64'd0);
      chk("rst_hash_count", 64'(hash_count), 64'd0);
      chk("rst_share_count", 64'(share_count), 64'd0);
      chk("rst_drop_count", 64'(drop_count), 64'd0);
      mq.delete();
      pend.delete();
      m_hash = '0;
      m_share = '0;
      m_drop = 0;
      repeat (hold) @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      mon_on = 1'b1;
   endtask

   logic [63:0] t_top;
   int          drops_before;

   initial begin
      #1;
      reset_pulse(2);
      enable = 1'b1;

      // Latency / qualify.
      target = 64'h00000000_FFFFFFFF;
      strobe(32'hDEADBEEF, 64'h0000_0000_1234_5678);
      idle(3);
      chk("lat_share_count", 64'(share_count), 64'd1);
      chk("lat_out_nonce", 64'(out_nonce), 64'hDEADBEEF);
      drain();

      // Inclusive boundary.
      target = 64'h10;
      strobe(32'h0000_0011, 64'h11);
      strobe(32'h0000_0010, 64'h10);
      strobe(32'h0000_000F, 64'h0F);
      idle(4);
      drain();

      // Mid-run reset with three entries held.
      ready_mode = 0;
      target = '1;
      for (int i = 0; i < 3; i++) strobe(32'hA000_0000 + 32'(i), 64'(i));
      idle(5);
      chk("pre_rst_level", 64'(fifo_level), 64'd3);
      reset_pulse(1);

      // Overflow: ten shares into eight slots.
      ready_mode = 0;
      target = 64'h0000_1000;
      for (int i = 0; i < 10; i++) strobe(32'hB000_0000 + 32'(i), 64'(i));
      idle(5);
      chk("ovf_level", 64'(fifo_level), 64'd8);
      chk("ovf_drop", 64'(drop_count), 64'd2);
      chk("ovf_share", 64'(share_count), 64'd10);
      drain();

      // Full FIFO with push and pop on the same edge.
      ready_mode = 0;
      for (int i = 0; i < 8; i++) strobe(32'hC000_0000 + 32'(i), 64'(i));
      idle(4);
      drops_before = int'(drop_count);
      strobe(32'hC000_00FF, 64'h5);
      @(negedge clk);
      ready_mode = 1;
      @(negedge clk);
      ready_mode = 0;
      idle(2);
      chk("fullpp_level", 64'(fifo_level), 64'd8);
      chk("fullpp_drop", 64'(drop_count), 64'(drops_before));
      drain();

      // Enable gating, then enable dropping one cycle after the strobe.
      enable = 1'b0;
      for (int i = 0; i < 5; i++) strobe(32'hD000_0000 + 32'(i), 64'h0);
      idle(4);
      enable = 1'b1;
      strobe(32'hD000_00EE, 64'h0);
      enable = 1'b0;
      idle(4);
      enable = 1'b1;
      drain();

      // Randomized traffic with mid-flight target changes and random back-pressure.
      ready_mode = 2;
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: target = 64'h10;
               1: target = {$urandom, $urandom};
               2: target = '1;
               default: target = '0;
            endcase
         end
         if ($urandom_range(0, 9) == 0) enable = ~enable;
         case ($urandom_range(0, 3))
            0: t_top = target;
            1: t_top = target + 64'd1;
            2: t_top = target - 64'd1;
            default: t_top = {$urandom, $urandom};
         endcase
         strobe($urandom, t_top);
         idle($urandom_range(0, 3));
      end
      enable = 1'b1;
      drain();

      mon_on = 1'b0;
      idle(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
